// File: rtl/bitmap_plotter.sv
// Walks a packed glyph bitmap row-major and emits one framebuffer write per accepted pixel.
// Optional build macro BITMAP_PLOTTER_TRANSPARENT_EN: 0 bits are skipped instead of drawn in BG_COLOUR.
module bitmap_plotter #(
  parameter int COLS = 35,
  parameter int ROWS = 6,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 3
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [COLS*ROWS-1:0] BITMAP,
  input  logic [XW-1:0]        X_ORIGIN,
  input  logic [YW-1:0]        Y_ORIGIN,
  input  logic [CW-1:0]        FG_COLOUR,
  input  logic [CW-1:0]        BG_COLOUR,
  input  logic                 READY,
  output logic [XW-1:0]        X,
  output logic [YW-1:0]        Y,
  output logic [CW-1:0]        COLOUR,
  output logic                 PLOT,
  output logic                 BUSY,
  output logic                 DONE
);
  // Handshake: a write is taken on a cycle with PLOT=1 and READY=1; while PLOT=1 and
  // READY=0 the outputs and counters hold.
  localparam int NPIX = COLS * ROWS;
  localparam int CBW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RBW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
`ifdef BITMAP_PLOTTER_TRANSPARENT_EN
  localparam bit TRANSPARENT = 1'b1;
`else
  localparam bit TRANSPARENT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;
  state_t state;

  logic [NPIX-1:0] bitmap_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [CW-1:0]   fg_q;
  logic [CW-1:0]   bg_q;
  logic [CBW-1:0]  col;
  logic [RBW-1:0]  row;
  logic [IW-1:0]   idx;

  logic            last;
  logic            advance;
  logic [CBW-1:0]  col_n;
  logic [RBW-1:0]  row_n;
  logic [IW-1:0]   idx_n;
  logic            bit_n;

  // Next scan position; the registered outputs always describe the current (col,row).
  always_comb begin
    last    = (col == CBW'(COLS - 1)) && (row == RBW'(ROWS - 1));
    advance = READY || !PLOT;
    col_n   = col + CBW'(1);
    row_n   = row;
    idx_n   = idx + IW'(1);
    if (col == CBW'(COLS - 1)) begin
      col_n = '0;
      row_n = row + RBW'(1);
    end
    bit_n = bitmap_q[idx_n];
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      bitmap_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      col      <= '0;
      row      <= '0;
      idx      <= '0;
      X        <= '0;
      Y        <= '0;
      COLOUR   <= '0;
      PLOT     <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            bitmap_q <= BITMAP;
            x_q      <= X_ORIGIN;
            y_q      <= Y_ORIGIN;
            fg_q     <= FG_COLOUR;
            bg_q     <= BG_COLOUR;
            col      <= '0;
            row      <= '0;
            idx      <= '0;
            X        <= X_ORIGIN;
            Y        <= Y_ORIGIN;
            COLOUR   <= BITMAP[0] ? FG_COLOUR : BG_COLOUR;
            PLOT     <= TRANSPARENT ? BITMAP[0] : 1'b1;
            BUSY     <= 1'b1;
            state    <= DRAW;
          end
        end
        DRAW: begin
          if (advance) begin
            if (last) begin
              PLOT  <= 1'b0;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              state <= FINISH;
            end else begin
              col    <= col_n;
              row    <= row_n;
              idx    <= idx_n;
              X      <= x_q + XW'(col_n);
              Y      <= y_q + YW'(row_n);
              COLOUR <= bit_n ? fg_q : bg_q;
              PLOT   <= TRANSPARENT ? bit_n : 1'b1;
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitmap_plotter.sv
// Bench for bitmap_plotter: vector table, hand-written corner sequences and random draws
// checked against a coordinate-level model of the expected write stream.
module tb_bitmap_plotter;
  localparam int COLS = 35;
  localparam int ROWS = 6;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CW   = 3;
  localparam int NPIX = COLS * ROWS;
  localparam int W    = XW + YW + CW;
  localparam int CYC_LIMIT = 1500;
`ifdef BITMAP_PLOTTER_TRANSPARENT_EN
  localparam bit TRANSPARENT = 1'b1;
`else
  localparam bit TRANSPARENT = 1'b0;
`endif

  logic            CLOCK_50 = 1'b0;
  logic            RESET;
  logic            START;
  logic [NPIX-1:0] BITMAP;
  logic [XW-1:0]   X_ORIGIN;
  logic [YW-1:0]   Y_ORIGIN;
  logic [CW-1:0]   FG_COLOUR;
  logic [CW-1:0]   BG_COLOUR;
  logic            READY;
  logic [XW-1:0]   X;
  logic [YW-1:0]   Y;
  logic [CW-1:0]   COLOUR;
  logic            PLOT;
  logic            BUSY;
  logic            DONE;

  bitmap_plotter #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .CW(CW)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .START(START), .BITMAP(BITMAP),
    .X_ORIGIN(X_ORIGIN), .Y_ORIGIN(Y_ORIGIN), .FG_COLOUR(FG_COLOUR), .BG_COLOUR(BG_COLOUR),
    .READY(READY), .X(X), .Y(Y), .COLOUR(COLOUR), .PLOT(PLOT), .BUSY(BUSY), .DONE(DONE)
  );

  // ---------------- clock / reset
  always #5 CLOCK_50 = ~CLOCK_50;

  // ---------------- scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] log_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [NPIX-1:0] bm;
    logic [XW-1:0]   xo;
    logic [YW-1:0]   yo;
    logic [CW-1:0]   fg;
    logic [CW-1:0]   bg;
    int              ready_mode;   // 0 always, 1 toggle, 2 random
    int              restart_at;   // write index at which START is re-pulsed, -1 none
    int              exp_writes;   // -1: take count from the model
    int              exp_lat;      // DONE cycle after START edge, -1: not fixed
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [NPIX-1:0] rand_bitmap();
    logic [NPIX-1:0] b;
    for (int i = 0; i < NPIX; i++) b[i] = 1'($urandom_range(0, 1));
    return b;
  endfunction

  // Reference: every pixel in row-major order, coordinates wrapped by plain modulo.
  task automatic model_load(input logic [NPIX-1:0] bm, input logic [XW-1:0] xo,
                            input logic [YW-1:0] yo, input logic [CW-1:0] fg,
                            input logic [CW-1:0] bg);
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bit on;
        int x;
        int y;
        on = bm[r * COLS + c];
        x  = (int'(xo) + c) % (1 << XW);
        y  = (int'(yo) + r) % (1 << YW);
        if (TRANSPARENT && !on) continue;
        exp_q.push_back({x[XW-1:0], y[YW-1:0], on ? fg : bg});
      end
    end
  endtask

  // ---------------- driver + monitor for one draw
  task automatic do_draw(input vec_t v, input int reset_at,
                         output int writes, output int dones, output int done_cyc,
                         output bit aborted, output int model_n);
    logic [W-1:0] act_w;
    logic [W-1:0] hold_w;
    logic [W-1:0] e;
    logic hold;
    int cyc;
    int tail;
    model_load(v.bm, v.xo, v.yo, v.fg, v.bg);
    model_n = exp_q.size();
    log_q.delete();
    writes = 0; dones = 0; done_cyc = -1; aborted = 0; hold = 0; tail = 0; cyc = 0;
    hold_w = '0;
    @(posedge CLOCK_50); #1;
    BITMAP = v.bm; X_ORIGIN = v.xo; Y_ORIGIN = v.yo; FG_COLOUR = v.fg; BG_COLOUR = v.bg;
    START = 1'b1;
    @(posedge CLOCK_50); #1;
    START = 1'b0;
    while (cyc < CYC_LIMIT && tail < 3 && !aborted) begin
      // captured inputs must not matter once the draw has begun
      BITMAP = rand_bitmap(); X_ORIGIN = XW'($urandom); Y_ORIGIN = YW'($urandom);
      FG_COLOUR = CW'($urandom); BG_COLOUR = CW'($urandom);
      case (v.ready_mode)
        0: READY = 1'b1;
        1: READY = (cyc % 2 == 0);
        default: READY = 1'($urandom_range(0, 1));
      endcase
      START = (writes == v.restart_at) && (dones == 0);
      @(negedge CLOCK_50);
      cyc++;
      act_w = {X, Y, COLOUR};
      if (hold) begin
        check("hold_xyc", act_w, hold_w);
        check("hold_plot", PLOT, 1);
      end
      hold   = PLOT && !READY;
      hold_w = act_w;
      if (PLOT) check("busy_with_plot", BUSY, 1);
      if (PLOT && READY) begin
        check("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("write%0d_xyc", writes), act_w, e);
        end
        log_q.push_back(act_w);
        writes++;
      end
      if (DONE) begin
        dones++;
        done_cyc = cyc;
        check("busy_at_done", BUSY, 0);
        check("plot_at_done", PLOT, 0);
      end else if (dones > 0) begin
        check("plot_after_done", PLOT, 0);
        check("busy_after_done", BUSY, 0);
      end
      if (dones > 0) tail++;
      if (reset_at >= 0 && writes == reset_at) begin
        RESET = 1'b1;
        #1;
        check("abort_plot", PLOT, 0);
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_xyc", {X, Y, COLOUR}, 0);
        @(posedge CLOCK_50); #1;
        RESET = 1'b0;
        aborted = 1;
      end else begin
        @(posedge CLOCK_50); #1;
      end
    end
    START = 1'b0;
    READY = 1'b0;
    check("draw_finished_in_budget", (tail >= 3) || aborted, 1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int writes, dones, dcyc, model_n;
    bit aborted;
    do_draw(v, -1, writes, dones, dcyc, aborted, model_n);
    check({tag, "_write_count"}, writes, (v.exp_writes < 0) ? model_n : v.exp_writes);
    check({tag, "_done_count"}, dones, 1);
    check({tag, "_exp_q_empty"}, exp_q.size(), 0);
    if (v.exp_lat >= 0) check({tag, "_done_latency"}, dcyc, v.exp_lat);
  endtask

  // ---------------- stimulus
  vec_t vecs[6];
  logic [COLS-1:0] score_rows[ROWS];
  logic [NPIX-1:0] score;
  logic [NPIX-1:0] ones;
  logic [NPIX-1:0] zeros;
  logic [NPIX-1:0] bit36;

  initial begin
    vec_t v;
    logic [W-1:0] t;
    int writes, dones, dcyc, model_n;
    bit aborted;

    RESET = 1'b1; START = 1'b0; BITMAP = '0; X_ORIGIN = '0; Y_ORIGIN = '0;
    FG_COLOUR = '0; BG_COLOUR = '0; READY = 1'b0;
    #1;
    check("rst_x", X, 0);
    check("rst_y", Y, 0);
    check("rst_colour", COLOUR, 0);
    check("rst_plot", PLOT, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    @(posedge CLOCK_50); @(posedge CLOCK_50); #1;
    RESET = 1'b0;
    @(posedge CLOCK_50); #1;
    check("idle_plot", PLOT, 0);

    score_rows = '{35'h3_9CE7_3BE4, 35'h0_4210_8421, 35'h1_39CE_739C,
                   35'h4_2108_4210, 35'h3_9CE7_39CE, 35'h2_A5A5_5A5A};
    for (int r = 0; r < ROWS; r++) score[r * COLS +: COLS] = score_rows[r];
    ones  = '1;
    zeros = '0;
    bit36 = '0;
    bit36[36] = 1'b1;

`ifndef BITMAP_PLOTTER_TRANSPARENT_EN
    vecs[0] = '{score, 8'd10,  7'd5,   3'd7, 3'd0, 0, -1,  210, 211};
    vecs[1] = '{score, 8'd10,  7'd5,   3'd7, 3'd0, 1, -1,  210, -1};
    vecs[2] = '{score, 8'd10,  7'd5,   3'd7, 3'd0, 0, 50,  210, 211};
    vecs[3] = '{score, 8'd250, 7'd3,   3'd5, 3'd2, 0, 210, 210, 211};
    vecs[4] = '{ones,  8'd0,   7'd125, 3'd1, 3'd6, 2, -1,  210, -1};
    vecs[5] = '{zeros, 8'd100, 7'd100, 3'd3, 3'd4, 1, 80,  210, -1};
`else
    vecs[0] = '{zeros, 8'd10,  7'd5,  3'd7, 3'd0, 0, -1, 0,   211};
    vecs[1] = '{bit36, 8'd20,  7'd30, 3'd6, 3'd1, 0, -1, 1,   211};
    vecs[2] = '{score, 8'd10,  7'd5,  3'd7, 3'd0, 1, -1, -1,  -1};
    vecs[3] = '{ones,  8'd0,   7'd0,  3'd5, 3'd2, 0, -1, 210, 211};
    vecs[4] = '{bit36, 8'd1,   7'd2,  3'd3, 3'd4, 2, -1, 1,   -1};
    vecs[5] = '{score, 8'd250, 7'd3,  3'd2, 3'd5, 0, 20, -1,  211};
`endif
    for (int i = 0; i < 6; i++) run_vec($sformatf("v%0d", i), vecs[i]);

`ifndef BITMAP_PLOTTER_TRANSPARENT_EN
    // SCORE at (10,5): first, third and last write
    v = '{score, 8'd10, 7'd5, 3'd7, 3'd0, 0, -1, 210, 211};
    run_vec("score", v);
    t = log_q[0];
    check("score_first", t, {8'd10, 7'd5, 3'd0});
    t = log_q[2];
    check("score_px2_fg", t[CW-1:0], 3'd7);
    t = log_q[209];
    check("score_last_xy", t[W-1:CW], {8'd44, 7'd10});
`else
    // single set bit 36 lands at column 1, row 1
    v = '{bit36, 8'd20, 7'd30, 3'd6, 3'd1, 0, -1, 1, 211};
    run_vec("bit36", v);
    t = log_q[0];
    check("bit36_xyc", t, {8'd21, 7'd31, 3'd6});
`endif

    // X wrap: origin 250, column 6 lands on X=0
    v = '{ones, 8'd250, 7'd3, 3'd7, 3'd0, 0, -1, 210, 211};
    run_vec("wrap", v);
    t = log_q[5];
    check("wrap_col5_x", t[W-1:YW+CW], 255);
    t = log_q[6];
    check("wrap_col6_x", t[W-1:YW+CW], 0);
    check("wrap_col6_y", t[YW+CW-1:CW], 3);

    // reset at write 100, then a clean restart from the origin
    v = '{ones, 8'd40, 7'd20, 3'd7, 3'd1, 0, -1, 210, 211};
    do_draw(v, 100, writes, dones, dcyc, aborted, model_n);
    check("abort_writes", writes, 100);
    check("abort_no_done", dones, 0);
    v = '{ones, 8'd17, 7'd9, 3'd2, 3'd5, 0, -1, 210, 211};
    run_vec("after_reset", v);
    t = log_q[0];
    check("after_reset_first", t, {8'd17, 7'd9, 3'd2});

    // random draws
    for (int k = 0; k < 4; k++) begin
      v.bm = rand_bitmap();
      v.xo = XW'($urandom);
      v.yo = YW'($urandom);
      v.fg = CW'($urandom);
      v.bg = CW'($urandom);
      v.ready_mode = $urandom_range(0, 2);
      v.restart_at = $urandom_range(0, 1) ? int'($urandom_range(1, 100)) : -1;
      v.exp_writes = -1;
      v.exp_lat = (v.ready_mode == 0) ? 211 : -1;
      run_vec($sformatf("rnd%0d", k), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bitmap_plotter.md
Name: bitmap_plotter

Overview:
- Consumer of the packed glyph bitmaps produced by the text ROMs, for example the 210-bit "SCORE" word: 6 rows × 35 columns, with row r in bits [35r+34 : 35r].
- Walks the bitmap one pixel per accepted cycle and emits (X, Y, COLOUR, PLOT) writes toward the VGA framebuffer adapter.
- Sits between the text ROMs and the framebuffer write arbiter.
- Issues a DONE pulse when the whole glyph block has been drawn.

Parameters:
- COLS, 35, columns per bitmap row.
- ROWS, 6, rows per bitmap (BITMAP width = COLS*ROWS).
- XW, 8, X coordinate width.
- YW, 7, Y coordinate width.
- CW, 3, colour width.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  request to draw; sampled only in IDLE.
- BITMAP  input  COLS*ROWS  packed glyph; pixel (c,r) = BITMAP[COLS*r + c], c=0 is the leftmost column.
- X_ORIGIN  input  XW  screen X of the top-left pixel.
- Y_ORIGIN  input  YW  screen Y of the top-left pixel.
- FG_COLOUR  input  CW  colour for 1 bits.
- BG_COLOUR  input  CW  colour for 0 bits.
- READY  input  1  framebuffer accepts the write this cycle.
- X  output  XW  pixel X.
- Y  output  YW  pixel Y.
- COLOUR  output  CW  pixel colour.
- PLOT  output  1  write strobe.
- BUSY  output  1  high from capture through the last write.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, RESET high): state IDLE; X, Y, COLOUR, PLOT, BUSY, DONE all 0; column and row counters 0.
- State IDLE:
  - START=1 captures BITMAP, X_ORIGIN, Y_ORIGIN, FG_COLOUR and BG_COLOUR into internal registers.
  - Sets counters c=0, r=0 and moves to DRAW.
  - Later changes on these inputs do not affect a draw in progress.
- State DRAW:
  - Registered outputs: X = X_ORIGIN_q + c, truncated to XW bits so it wraps modulo 2^XW.
  - Y = Y_ORIGIN_q + r, truncated to YW bits.
  - COLOUR = FG_COLOUR_q if the bit is 1, else BG_COLOUR_q.
  - PLOT=1.
  - First PLOT appears the cycle after START is sampled.
- Handshake:
  - A write is accepted on a cycle where PLOT=1 and READY=1.
  - While READY=0, X, Y, COLOUR and PLOT hold stable and the counters do not advance.
- Scan order:
  - On accept, c increments.
  - When c=COLS-1, c returns to 0 and r increments (row-major, left to right, top to bottom).
- Last pixel: accept at c=COLS-1, r=ROWS-1 moves to state FINISH. PLOT drops to 0 in that same next cycle.
- State FINISH: DONE=1 for exactly one cycle, BUSY=0, then IDLE. A START during FINISH is ignored.
- BUSY is 1 in DRAW only.
- START while in DRAW or FINISH is ignored; it is not queued.
- Total time with READY held at 1: START cycle, then COLS*ROWS PLOT cycles (210), then 1 DONE cycle.
- RESET asserted mid-draw aborts immediately to IDLE with all outputs 0. No DONE is issued.
- START asserted in the same cycle that FINISH returns to IDLE is ignored. The next START is sampled in IDLE.

Optional Feature:
- Macro: BITMAP_PLOTTER_TRANSPARENT_EN.
- Defined:
  - 0 bits are skipped. PLOT=0 for them and the counters advance one position per cycle without waiting for READY.
  - Only 1 bits produce writes, and BG_COLOUR is unused.
  - The X, Y and COLOUR values driven while PLOT=0 are don't-care.
  - DONE still fires one cycle after the final position is passed, whether that position was plotted or skipped.
- Undefined: every pixel is written as described in Behaviour.

Test Plan:
- SCORE bitmap, X_ORIGIN=10, Y_ORIGIN=5, FG=3'b111, BG=3'b000, READY=1, pulse START:
  - Exactly 210 PLOT cycles, first write at (10,5), last at (44,10).
  - Pixel (0,0) is BG, pixel (2,0) is FG.
  - DONE pulses once, 211 cycles after START.
- Same draw with READY toggling 1,0,1,0 during DRAW: still exactly 210 accepted writes in the same order; outputs stable during every READY=0 cycle.
- X_ORIGIN=250 with XW=8: column 6 is written at X=0 (wrap); Y is unaffected.
- START pulsed again at write #50: ignored; total writes remain 210 and only one DONE.
- RESET asserted at write #100: PLOT, BUSY and DONE go to 0 immediately. A new START then restarts at (X_ORIGIN, Y_ORIGIN).
- With BITMAP_PLOTTER_TRANSPARENT_EN defined, all-zero BITMAP: zero PLOT cycles and DONE 211 cycles after START. With a single bit 36 set: exactly one write, at (X_ORIGIN+1, Y_ORIGIN+1) in FG.
